// File: rtl/xosera_reboot_ctrl.sv
// Warm-boot sequencer: checks the unlock key, waits for a quiet 68k bus, blanks video,
// then drives SB_WARMBOOT. Every output comes straight from a flop.
module xosera_reboot_ctrl #(
  parameter logic [15:0] KEY          = 16'hB007,
  parameter int unsigned IDLE_CYCLES  = 16,
  parameter int unsigned BLANK_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       req_i,
  input  logic [15:0] req_key_i,
  input  logic [1:0] req_sel_i,
  input  logic       cancel_i,
  input  logic       bus_cs_n_i,
  input  logic       pll_lock_i,
  output logic       busy_o,
  output logic       blank_o,
  output logic       reconfig_o,
  output logic [1:0] boot_select_o,
  output logic       key_err_o
);

  localparam int unsigned MaxCycles = (IDLE_CYCLES > BLANK_CYCLES) ? IDLE_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] IdleLast  = CntW'(IDLE_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StArmed, StQuiet, StBlank, StBoot} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            cs_meta_q, cs_sync_q;
  logic            key_err_d;
  logic            abort;

  logic            busy_q, blank_q, reconfig_q, key_err_q;
  logic            busy_d, blank_d, reconfig_d;
  logic [1:0]      boot_sel_q, boot_sel_d;

  // Bus select pin is asynchronous to the pixel clock; resets to deselected.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cs_meta_q <= 1'b1;
      cs_sync_q <= 1'b1;
    end else begin
      cs_meta_q <= bus_cs_n_i;
      cs_sync_q <= cs_meta_q;
    end
  end

  assign abort = cancel_i | ~pll_lock_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    key_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          if (req_key_i == KEY) begin
            sel_d   = req_sel_i;
            cnt_d   = '0;
            state_d = StArmed;
          end else begin
            key_err_d = 1'b1;
          end
        end
      end
      StArmed: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StQuiet;
        end
      end
      StQuiet: begin
        if (abort) begin
          state_d = StIdle;
        end else if (!cs_sync_q) begin
          cnt_d = '0;
        end else if (cnt_q == IdleLast) begin
          cnt_d   = '0;
          state_d = StBlank;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBlank: begin
        if (abort) begin
          state_d = StIdle;
        end else if (cnt_q == BlankLast) begin
          state_d = StBoot;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StBoot: begin
        // Terminal; only reset leaves.
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they land in flops on the same edge.
  always_comb begin
    busy_d     = (state_d != StIdle);
    blank_d    = (state_d == StBlank) || (state_d == StBoot);
    reconfig_d = (state_d == StBoot);
    boot_sel_d = (state_d == StBoot) ? sel_d : 2'b00;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= 2'b00;
      busy_q     <= 1'b0;
      blank_q    <= 1'b0;
      reconfig_q <= 1'b0;
      boot_sel_q <= 2'b00;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      busy_q     <= busy_d;
      blank_q    <= blank_d;
      reconfig_q <= reconfig_d;
      boot_sel_q <= boot_sel_d;
      key_err_q  <= key_err_d;
    end
  end

  assign busy_o        = busy_q;
  assign blank_o       = blank_q;
  assign reconfig_o    = reconfig_q;
  assign boot_select_o = boot_sel_q;
  assign key_err_o     = key_err_q;

endmodule

// File: tb/tb_xosera_reboot_ctrl.sv
// Bench for xosera_reboot_ctrl: directed sequences, a per-cycle behavioural model and
// literal checks at the key cycle offsets.
module tb_xosera_reboot_ctrl;

  localparam int unsigned IdleCycles  = 4;
  localparam int unsigned BlankCycles = 8;
  localparam logic [15:0] Key         = 16'hB007;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [15:0] req_key = 16'h0000;
  logic [1:0]  req_sel = 2'b00;
  logic        cancel = 1'b0;
  logic        bus_cs_n = 1'b1;
  logic        pll_lock = 1'b1;
  logic        busy_o, blank_o, reconfig_o, key_err_o;
  logic [1:0]  boot_select_o;

  xosera_reboot_ctrl #(
    .KEY          (Key),
    .IDLE_CYCLES  (IdleCycles),
    .BLANK_CYCLES (BlankCycles)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n),
    .req_i         (req),
    .req_key_i     (req_key),
    .req_sel_i     (req_sel),
    .cancel_i      (cancel),
    .bus_cs_n_i    (bus_cs_n),
    .pll_lock_i    (pll_lock),
    .busy_o        (busy_o),
    .blank_o       (blank_o),
    .reconfig_o    (reconfig_o),
    .boot_select_o (boot_select_o),
    .key_err_o     (key_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Model: phase 0 idle, 1 armed, 2 waiting for quiet bus, 3 blanking, 4 booted.
  int         m_phase;
  int         m_quiet_run;
  int         m_blank_done;
  logic [1:0] m_sel;
  logic       m_key_err;
  logic       m_pin_prev1, m_pin_prev2;
  bit         model_ready = 1'b0;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_quiet_run  = 0;
    m_blank_done = 0;
    m_sel        = 2'b00;
    m_key_err    = 1'b0;
    m_pin_prev1  = 1'b1;
    m_pin_prev2  = 1'b1;
  endtask

  // One rising edge: the controller sees the bus pin as it was two edges ago.
  task automatic model_step();
    logic seen_cs_n;
    seen_cs_n = m_pin_prev2;
    m_key_err = 1'b0;
    if (m_phase == 0) begin
      if (req) begin
        if (req_key == Key) begin
          m_sel   = req_sel;
          m_phase = 1;
        end else begin
          m_key_err = 1'b1;
        end
      end
    end else if (m_phase != 4 && (cancel || !pll_lock)) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      m_phase     = 2;
      m_quiet_run = 0;
    end else if (m_phase == 2) begin
      if (!seen_cs_n) begin
        m_quiet_run = 0;
      end else begin
        m_quiet_run++;
        if (m_quiet_run == IdleCycles) begin
          m_phase      = 3;
          m_blank_done = 0;
        end
      end
    end else if (m_phase == 3) begin
      m_blank_done++;
      if (m_blank_done == BlankCycles) m_phase = 4;
    end
    m_pin_prev2 = m_pin_prev1;
    m_pin_prev1 = bus_cs_n;
  endtask

  always @(negedge clk) begin
    if (model_ready) begin
      chk("busy", {1'b0, busy_o}, {1'b0, m_phase != 0});
      chk("blank", {1'b0, blank_o}, {1'b0, m_phase >= 3});
      chk("reconfig", {1'b0, reconfig_o}, {1'b0, m_phase == 4});
      chk("boot_select", boot_select_o, (m_phase == 4) ? m_sel : 2'b00);
      chk("key_err", {1'b0, key_err_o}, {1'b0, m_key_err});
    end
  end

  task automatic step(input logic r, input logic [15:0] k, input logic [1:0] s, input logic c);
    req     = r;
    req_key = k;
    req_sel = s;
    cancel  = c;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    req    = 1'b0;
    cancel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 2'b00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {1'b0, busy_o}, 2'b00);
    chk({tag, "_blank"}, {1'b0, blank_o}, 2'b00);
    chk({tag, "_reconfig"}, {1'b0, reconfig_o}, 2'b00);
    chk({tag, "_sel"}, boot_select_o, 2'b00);
    chk({tag, "_key_err"}, {1'b0, key_err_o}, 2'b00);
  endtask

  // Called at posedge+1; asserts reset between edges and checks before any edge.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all_zero(tag);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    model_ready = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    // Nominal reboot, then cancel in BOOT is ignored, then async reset.
    step(1'b1, Key, 2'b10, 1'b0);
    chk("t1_busy_p1", {1'b0, busy_o}, 2'b01);
    chk("t1_blank_p1", {1'b0, blank_o}, 2'b00);
    for (int e = 2; e <= 16; e++) begin
      idle(1);
      if (e == 5) chk("t1_blank_p5", {1'b0, blank_o}, 2'b00);
      if (e == 6) chk("t1_blank_p6", {1'b0, blank_o}, 2'b01);
      if (e == 13) chk("t1_reconfig_p13", {1'b0, reconfig_o}, 2'b00);
      if (e == 14) begin
        chk("t1_reconfig_p14", {1'b0, reconfig_o}, 2'b01);
        chk("t1_sel_p14", boot_select_o, 2'b10);
      end
    end
    chk("t1_sel_held", boot_select_o, 2'b10);
    step(1'b0, 16'h0000, 2'b00, 1'b1);
    chk("t4_cancel_in_boot", {1'b0, reconfig_o}, 2'b01);
    async_reset("t1_rst");

    // Bad key, then a valid request runs to boot.
    step(1'b1, 16'h1234, 2'b11, 1'b0);
    chk("t2_key_err_p1", {1'b0, key_err_o}, 2'b01);
    chk("t2_busy_p1", {1'b0, busy_o}, 2'b00);
    idle(1);
    chk("t2_key_err_p2", {1'b0, key_err_o}, 2'b00);
    step(1'b1, Key, 2'b01, 1'b0);
    idle(13);
    chk("t2_reconfig", {1'b0, reconfig_o}, 2'b01);
    chk("t2_sel", boot_select_o, 2'b01);
    async_reset("t2_rst");

    // Bus select pulse during QUIET restarts the quiet count; then cancel mid-blank.
    step(1'b1, Key, 2'b11, 1'b0);
    idle(1);
    bus_cs_n = 1'b0;
    idle(1);
    bus_cs_n = 1'b1;
    idle(5);
    chk("t3_blank_p8", {1'b0, blank_o}, 2'b00);
    idle(1);
    chk("t3_blank_p9", {1'b0, blank_o}, 2'b01);
    idle(5);
    step(1'b0, 16'h0000, 2'b00, 1'b1);
    chk("t3_blank_after_cancel", {1'b0, blank_o}, 2'b00);
    chk("t3_busy_after_cancel", {1'b0, busy_o}, 2'b00);
    idle(20);
    chk("t3_no_reconfig", {1'b0, reconfig_o}, 2'b00);

    // PLL loss in QUIET aborts.
    step(1'b1, Key, 2'b00, 1'b0);
    idle(2);
    pll_lock = 1'b0;
    idle(1);
    pll_lock = 1'b1;
    chk("t4_busy_pll", {1'b0, busy_o}, 2'b00);
    idle(3);
    chk("t4_busy_later", {1'b0, busy_o}, 2'b00);

    // Request with cancel in IDLE is taken; later requests in QUIET are ignored.
    step(1'b1, Key, 2'b10, 1'b1);
    chk("t5_busy", {1'b0, busy_o}, 2'b01);
    idle(1);
    step(1'b1, Key, 2'b01, 1'b0);
    step(1'b1, 16'hDEAD, 2'b00, 1'b0);
    chk("t5_no_key_err", {1'b0, key_err_o}, 2'b00);
    idle(10);
    chk("t5_reconfig", {1'b0, reconfig_o}, 2'b01);
    chk("t5_sel", boot_select_o, 2'b10);
    async_reset("t5_rst");
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
